// File: rtl/riscv_multicycle_control.sv
// Multicycle main control FSM for the RISC-V core: sequences fetch, decode, execute,
// memory and writeback for one instruction per start request.
module riscv_multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr_rdata,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [1:0]  alu_op,
  output logic [6:0]  func7,
  output logic [2:0]  func3,
  output logic        alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t           state, next_state;
  logic [31:0]      ir, ir_next;
  logic [6:0]       opcode, next_opcode;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  assign ir_next      = (state == FETCH && mem_ready) ? instr_rdata : ir;
  assign opcode       = ir[6:0];
  assign next_opcode  = ir_next[6:0];
  assign func7        = ir[31:25];
  assign func3        = ir[14:12];
  assign wait_expired = !mem_ready && (wait_cnt == LAST_WAIT);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (mem_ready) next_state = DECODE;
               else if (wait_expired) next_state = IDLE;
      DECODE:  next_state = is_legal(opcode) ? EXEC : IDLE;
      EXEC: begin
        if (opcode == OP_R || opcode == OP_I) next_state = WB;
        else if (opcode == OP_LOAD || opcode == OP_STORE) next_state = MEM;
        else next_state = IDLE;
      end
      MEM:     if (mem_ready) next_state = (opcode == OP_LOAD) ? WB : IDLE;
               else if (wait_expired) next_state = IDLE;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs are registered from the destination state so they change with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ir         <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
      alu_op     <= 2'b00;
      alu_src_b  <= 1'b0;
    end else begin
      state <= next_state;
      ir    <= ir_next;
      if ((next_state == FETCH || next_state == MEM) && next_state != state)
        wait_cnt <= '0;
      else if ((state == FETCH || state == MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;

      busy       <= (next_state != IDLE);
      mem_read   <= (next_state == FETCH) || (next_state == MEM && next_opcode == OP_LOAD);
      mem_write  <= (next_state == MEM && next_opcode == OP_STORE);
      reg_write  <= (next_state == WB);
      mem_to_reg <= (next_state == WB && next_opcode == OP_LOAD);
      illegal    <= (next_state == DECODE) && !is_legal(next_opcode);

      alu_op    <= 2'b00;
      alu_src_b <= 1'b0;
      // Operand selection is held from EXEC through MEM and WB for address/operand stability.
      if (next_state == EXEC || next_state == MEM || next_state == WB) begin
        case (next_opcode)
          OP_R:              alu_op <= 2'b10;
          OP_I:              begin alu_op <= 2'b10; alu_src_b <= 1'b1; end
          OP_LOAD, OP_STORE: begin alu_op <= 2'b00; alu_src_b <= 1'b1; end
          OP_BRANCH:         alu_op <= 2'b01;
          default:           alu_op <= 2'b00;
        endcase
      end
    end
  end

  // These strobes react to the memory/compare handshake in the same cycle.
  assign ir_write = (state == FETCH) && mem_ready;
  assign pc_write = ir_write || (state == EXEC && opcode == OP_BRANCH && branch_taken);
  assign done     = (state == WB) ||
                    (state == EXEC && opcode == OP_BRANCH) ||
                    (state == MEM && opcode == OP_STORE && mem_ready);
  assign timeout  = (state == FETCH || state == MEM) && wait_expired;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Self-checking bench for riscv_multicycle_control: per-cycle expected outputs are queued
// by the driver and compared by a monitor a moment later in the same cycle.
module tb_riscv_multicycle_control;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] instr_rdata;
  logic        mem_ready;
  logic        branch_taken;
  logic [1:0]  alu_op;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic        alu_src_b, ir_write, pc_write, mem_read, mem_write;
  logic        reg_write, mem_to_reg, busy, done, illegal, timeout;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_ir;
  int          checks;
  int          fails;

  riscv_multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_rdata(instr_rdata),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .alu_op(alu_op),
    .func7(func7), .func3(func3), .alu_src_b(alu_src_b), .ir_write(ir_write),
    .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy), .done(done),
    .illegal(illegal), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Vector layout: busy done illegal timeout alu_op alu_src_b mem_read mem_write
  // reg_write mem_to_reg pc_write ir_write func7 func3
  function automatic logic [22:0] ev(input logic b, d, il, to, input logic [1:0] ao,
                                     input logic sbv, mr, mw, rw, m2r, pcw, irw);
    return {b, d, il, to, ao, sbv, mr, mw, rw, m2r, pcw, irw, exp_ir[31:25], exp_ir[14:12]};
  endfunction

  task automatic applyStimulus(input string tag, input logic st, mr, bt,
                               input logic [31:0] rd, input logic rst, input logic [22:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    start        = st;
    mem_ready    = mr;
    branch_taken = bt;
    instr_rdata  = rd;
    e.tag = tag;
    e.v   = expv;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.tag,
          {9'd0, busy, done, illegal, timeout, alu_op, alu_src_b, mem_read, mem_write,
           reg_write, mem_to_reg, pc_write, ir_write, func7, func3},
          {9'd0, e.v});
      end
    end
  end

  task automatic idleTail(input string tag);
    applyStimulus({tag, "/tail"}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                  ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // One instruction from start to a trailing IDLE cycle; fw/mw are memory wait cycles
  // (>= TO means mem_ready never arrives), noisy holds start high while busy.
  task automatic runInstr(input string tag, input logic [31:0] instr, input int fw, input int mw,
                          input logic taken, input logic noisy);
    logic [6:0] op;
    logic [1:0] ao;
    logic       sbv, ld, st, br, legal;
    op    = instr[6:0];
    ld    = (op == 7'b0000011);
    st    = (op == 7'b0100011);
    br    = (op == 7'b1100011);
    legal = ld || st || br || (op == 7'b0110011) || (op == 7'b0010011);
    ao    = (ld || st) ? 2'b00 : (br ? 2'b01 : 2'b10);
    sbv   = ld || st || (op == 7'b0010011);

    applyStimulus({tag, "/idle"}, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
                  ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < fw && i < TO; i++)
      applyStimulus({tag, "/fetch_wait"}, noisy, 1'b0, 1'b0, 32'h0, 1'b0,
                    ev(1, 0, 0, (i == TO - 1), 2'b00, 0, 1, 0, 0, 0, 0, 0));
    if (fw >= TO) begin idleTail(tag); return; end
    applyStimulus({tag, "/fetch"}, noisy, 1'b1, 1'b0, instr, 1'b0,
                  ev(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1, 1));
    exp_ir = instr;
    applyStimulus({tag, "/decode"}, noisy, 1'b0, 1'b0, 32'h0, 1'b0,
                  ev(1, 0, !legal, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    if (!legal) begin idleTail(tag); return; end
    applyStimulus({tag, "/exec"}, noisy, 1'b0, taken, 32'h0, 1'b0,
                  ev(1, br, 0, 0, ao, sbv, 0, 0, 0, 0, br && taken, 0));
    if (br) begin idleTail(tag); return; end
    if (ld || st) begin
      for (int i = 0; i < mw && i < TO; i++)
        applyStimulus({tag, "/mem_wait"}, noisy, 1'b0, 1'b0, 32'h0, 1'b0,
                      ev(1, 0, 0, (i == TO - 1), ao, sbv, ld, st, 0, 0, 0, 0));
      if (mw >= TO) begin idleTail(tag); return; end
      applyStimulus({tag, "/mem"}, noisy, 1'b1, 1'b0, 32'h0, 1'b0,
                    ev(1, st, 0, 0, ao, sbv, ld, st, 0, 0, 0, 0));
      if (st) begin idleTail(tag); return; end
    end
    applyStimulus({tag, "/wb"}, noisy, 1'b0, 1'b0, 32'h0, 1'b0,
                  ev(1, 1, 0, 0, ao, sbv, 0, 0, 1, ld, 0, 0));
    idleTail(tag);
  endtask

  logic [31:0] pool [0:5];

  initial begin
    checks       = 0;
    fails        = 0;
    exp_ir       = 32'h0;
    reset        = 1'b1;
    start        = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    instr_rdata  = 32'h0;
    pool[0] = 32'h002081B3;  // add
    pool[1] = 32'h402081B3;  // sub
    pool[2] = 32'h0FF17093;  // andi
    pool[3] = 32'h00812283;  // lw
    pool[4] = 32'h00512623;  // sw
    pool[5] = 32'h00208463;  // beq

    applyStimulus("reset0", 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("reset1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("idle", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    runInstr("add", 32'h002081B3, 0, 0, 1'b0, 1'b0);
    runInstr("andi", 32'h0FF17093, 3, 0, 1'b0, 1'b0);
    runInstr("sub_noisy", 32'h402081B3, 1, 0, 1'b0, 1'b1);
    runInstr("lw", 32'h00812283, 1, 2, 1'b0, 1'b0);
    runInstr("sw", 32'h00512623, 0, 3, 1'b0, 1'b0);
    runInstr("beq_taken", 32'h00208463, 0, 0, 1'b1, 1'b0);
    runInstr("beq_not", 32'h00208463, 2, 0, 1'b0, 1'b1);
    runInstr("illegal", 32'h0000007F, 0, 0, 1'b0, 1'b0);
    runInstr("fetch_timeout", 32'h002081B3, TO, 0, 1'b0, 1'b0);
    runInstr("fetch_last", 32'h402081B3, TO - 1, 0, 1'b0, 1'b0);
    runInstr("mem_timeout", 32'h00812283, 0, TO, 1'b0, 1'b0);
    runInstr("mem_last", 32'h00512623, 0, TO - 1, 1'b0, 1'b0);

    // Reset in MEM of a store, with start pulsed while busy
    applyStimulus("rst_mem/idle", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_mem/fetch", 1'b0, 1'b1, 1'b0, 32'h00512623, 1'b0, ev(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1, 1));
    exp_ir = 32'h00512623;
    applyStimulus("rst_mem/decode", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ev(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_mem/exec", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_mem/mem", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev(1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0));
    exp_ir = 32'h0;
    applyStimulus("rst_mem/reset", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_mem/after0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("rst_mem/after1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < 8; k++)
      runInstr("rand", pool[$urandom_range(0, 5)], int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    @(posedge clk);
    #3;
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
